// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types, counter encodings and helper functions for the gshare predictor.
package gshare_branch_predictor_pkg;

    // Resolved-branch record produced (and registered) by the CMP unit.
    typedef struct packed {
        logic        we;
        logic        taken;
        logic [31:0] pc;
    } cmp_to_IF;

    // 2-bit saturating direction counter; MSB is the predicted direction.
    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t CTR_SNT = 2'b00;
    localparam bp_ctr_t CTR_WNT = 2'b01;
    localparam bp_ctr_t CTR_WT  = 2'b10;
    localparam bp_ctr_t CTR_ST  = 2'b11;

    // Gshare index before truncation: word address XOR zero-extended history.
    // Callers keep the low PHT index bits, which equals pc[IDX_W+1:2] ^ hist
    // as long as the history is no wider than the index.
    function automatic logic [31:0] bp_idx(input logic [31:0] pc, input logic [31:0] hist);
        return {2'b00, pc[31:2]} ^ hist;
    endfunction

    // Saturating train step: count up on taken, down on not-taken.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t old, input logic taken);
        bp_ctr_t nxt;
        nxt = old;
        if (taken) begin
            if (old != CTR_ST) nxt = bp_ctr_t'(old + 2'd1);
        end else begin
            if (old != CTR_SNT) nxt = bp_ctr_t'(old - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side lookup/prediction bus between IF and the predictor.
interface gshare_branch_predictor_if;

    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;

    // IF side drives lookups and consumes predictions.
    modport master (
        output lookup_valid,
        output lookup_pc,
        input  pred_valid,
        input  pred_taken,
        input  pred_pc
    );

    // Predictor side.
    modport slave (
        input  lookup_valid,
        input  lookup_pc,
        output pred_valid,
        output pred_taken,
        output pred_pc
    );

endinterface

// File: rtl/gshare_branch_predictor_pht.sv
// Pattern history table: flop array of 2-bit counters with one write port and
// two combinational read ports. Reads that hit the pending write see the new
// value, so a read never observes a counter one update behind.
module gshare_branch_predictor_pht
    import gshare_branch_predictor_pkg::*;
#(
    parameter int      IDX_W    = 8,
    parameter bp_ctr_t CTR_INIT = CTR_WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bp_ctr_t          wr_val,
    input  logic [IDX_W-1:0] rd0_idx,
    output bp_ctr_t          rd0_val,
    input  logic [IDX_W-1:0] rd1_idx,
    output bp_ctr_t          rd1_val
);

    localparam int DEPTH = 1 << IDX_W;

    bp_ctr_t ctr_arr [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            bp_ctr_t ctr_q;
            bp_ctr_t ctr_d;

            // Entry takes the write data only when the write port targets it.
            always_comb begin
                ctr_d = ctr_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) ctr_d = wr_val;
            end

            // Counter storage; reset returns every entry to the initial value.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) ctr_q <= CTR_INIT;
                else      ctr_q <= ctr_d;
            end

            assign ctr_arr[gi] = ctr_q;
        end
    endgenerate

    // Read ports with forwarding from the in-flight write.
    always_comb begin
        rd0_val = ctr_arr[rd0_idx];
        rd1_val = ctr_arr[rd1_idx];
        if (wr_en && (wr_idx == rd0_idx)) rd0_val = wr_val;
        if (wr_en && (wr_idx == rd1_idx)) rd1_val = wr_val;
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: registered 1-cycle lookup for IF, two-stage
// training pipeline (U1 read/modify, U2 write) driven by resolved branches
// from CMP, and a non-speculative global history register.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int      PHT_IDX_W = 8,
    parameter int      GHR_W     = 8,
    parameter bp_ctr_t CTR_INIT  = CTR_WNT
) (
    input  logic                            clk,
    input  logic                            rst,
    gshare_branch_predictor_if.slave        bp_if,
    input  cmp_to_IF                        cmp_in,
    output logic [GHR_W-1:0]                ghr_out,
    output logic [31:0]                     upd_cnt
);

    logic [GHR_W-1:0]     ghr_q,        ghr_d;
    logic [31:0]          upd_cnt_q,    upd_cnt_d;
    logic                 u2_valid_q,   u2_valid_d;
    logic [PHT_IDX_W-1:0] u2_idx_q,     u2_idx_d;
    bp_ctr_t              u2_val_q,     u2_val_d;
    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [31:0]          pred_pc_q,    pred_pc_d;

    logic [PHT_IDX_W-1:0] lk_idx;
    logic [PHT_IDX_W-1:0] u1_idx;
    bp_ctr_t              lk_ctr;
    bp_ctr_t              u1_ctr;

    // Both lookup and training index with the committed (pre-shift) history.
    assign lk_idx = PHT_IDX_W'(bp_idx(bp_if.lookup_pc, 32'(ghr_q)));
    assign u1_idx = PHT_IDX_W'(bp_idx(cmp_in.pc, 32'(ghr_q)));

    gshare_branch_predictor_pht #(
        .IDX_W    (PHT_IDX_W),
        .CTR_INIT (CTR_INIT)
    ) u_pht (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (u2_valid_q),
        .wr_idx  (u2_idx_q),
        .wr_val  (u2_val_q),
        .rd0_idx (lk_idx),
        .rd0_val (lk_ctr),
        .rd1_idx (u1_idx),
        .rd1_val (u1_ctr)
    );

    // Prediction for this cycle's lookup; pred_pc holds when no lookup.
    always_comb begin
        pred_valid_d = bp_if.lookup_valid;
        pred_taken_d = bp_if.lookup_valid & lk_ctr[1];
        pred_pc_d    = pred_pc_q;
        if (bp_if.lookup_valid) pred_pc_d = bp_if.lookup_pc;
    end

    // U1: compute the trained counter, shift history and count the update.
    always_comb begin
        u2_valid_d = cmp_in.we;
        u2_idx_d   = u2_idx_q;
        u2_val_d   = u2_val_q;
        ghr_d      = ghr_q;
        upd_cnt_d  = upd_cnt_q;
        if (cmp_in.we) begin
            u2_idx_d  = u1_idx;
            u2_val_d  = bp_ctr_next(u1_ctr, cmp_in.taken);
            ghr_d     = {ghr_q[GHR_W-2:0], cmp_in.taken};
            upd_cnt_d = upd_cnt_q + 32'd1;
        end
    end

    // State registers; reset also discards any pending U2 write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q        <= '0;
            upd_cnt_q    <= '0;
            u2_valid_q   <= 1'b0;
            u2_idx_q     <= '0;
            u2_val_q     <= CTR_INIT;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
        end else begin
            ghr_q        <= ghr_d;
            upd_cnt_q    <= upd_cnt_d;
            u2_valid_q   <= u2_valid_d;
            u2_idx_q     <= u2_idx_d;
            u2_val_q     <= u2_val_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
        end
    end

    assign bp_if.pred_valid = pred_valid_q;
    assign bp_if.pred_taken = pred_taken_q;
    assign bp_if.pred_pc    = pred_pc_q;
    assign ghr_out          = ghr_q;
    assign upd_cnt          = upd_cnt_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed, table-driven bench for the gshare predictor. Counters are observed
// only through predictions, so each lookup is aimed at the trained index by
// choosing pc = (target_idx ^ ghr) << 2.
module tb_gshare_branch_predictor;
    import gshare_branch_predictor_pkg::*;

    logic       clk;
    logic       rst;
    cmp_to_IF   cmp_in;
    logic [7:0] ghr_out;
    logic [31:0] upd_cnt;

    gshare_branch_predictor_if bp_if();

    gshare_branch_predictor #(
        .PHT_IDX_W (8),
        .GHR_W     (8),
        .CTR_INIT  (2'b01)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bp_if   (bp_if),
        .cmp_in  (cmp_in),
        .ghr_out (ghr_out),
        .upd_cnt (upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        we;
        logic        tk;
        logic [31:0] upc;
        logic        pv;
        logic        pt;
        logic [31:0] ppc;
        logic [7:0]  ghr;
        logic [31:0] cnt;
    } vec_t;

    localparam int NVEC = 38;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic lv, input logic [31:0] lpc,
                                input logic we, input logic tk, input logic [31:0] upc,
                                input logic pv, input logic pt, input logic [31:0] ppc,
                                input logic [7:0] ghr, input logic [31:0] cnt);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.we = we; v.tk = tk; v.upc = upc;
        v.pv = pv; v.pt = pt; v.ppc = ppc; v.ghr = ghr; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic pv, input logic pt,
                           input logic [31:0] ppc, input logic [7:0] ghr, input logic [31:0] cnt);
        chk({tag, ".pred_valid"}, 32'(bp_if.pred_valid), 32'(pv));
        chk({tag, ".pred_taken"}, 32'(bp_if.pred_taken), 32'(pt));
        chk({tag, ".pred_pc"},    bp_if.pred_pc,         ppc);
        chk({tag, ".ghr_out"},    32'(ghr_out),          32'(ghr));
        chk({tag, ".upd_cnt"},    upd_cnt,               cnt);
    endtask

    task automatic apply(input int i);
        bp_if.lookup_valid = vecs[i].lv;
        bp_if.lookup_pc    = vecs[i].lpc;
        cmp_in = '{we: vecs[i].we, taken: vecs[i].tk, pc: vecs[i].upc};
        @(posedge clk);
        #1;
        $display("vec %0d lv=%0b lpc=%03h we=%0b tk=%0b upc=%03h -> pv=%0b pt=%0b ppc=%03h ghr=%02h cnt=%0d",
                 i, vecs[i].lv, vecs[i].lpc, vecs[i].we, vecs[i].tk, vecs[i].upc,
                 bp_if.pred_valid, bp_if.pred_taken, bp_if.pred_pc, ghr_out, upd_cnt);
        chk_all($sformatf("v%0d", i), vecs[i].pv, vecs[i].pt, vecs[i].ppc, vecs[i].ghr, vecs[i].cnt);
    endtask

    initial begin
        //             lv  lpc     we tk upc      pv pt ppc     ghr    cnt
        // Basic lookup, then two trainings at idx 0x40 and 0x41.
        vecs[0]  = mk(1, 32'h100, 0, 0, 32'h000, 1, 0, 32'h100, 8'h00, 0);
        vecs[1]  = mk(0, 32'h000, 1, 1, 32'h100, 0, 0, 32'h100, 8'h01, 1);
        vecs[2]  = mk(1, 32'h100, 1, 1, 32'h100, 1, 0, 32'h100, 8'h03, 2);
        vecs[3]  = mk(1, 32'h108, 0, 0, 32'h000, 1, 1, 32'h108, 8'h03, 2);  // idx 0x41 via bypass
        vecs[4]  = mk(1, 32'h10C, 0, 0, 32'h000, 1, 1, 32'h10C, 8'h03, 2);  // idx 0x40 from table
        vecs[5]  = mk(1, 32'h100, 0, 0, 32'h000, 1, 0, 32'h100, 8'h03, 2);  // idx 0x43 untouched
        // Clear history with not-taken updates; first one knocks idx 0x41 back to 01.
        vecs[6]  = mk(0, 32'h000, 1, 0, 32'h108, 0, 0, 32'h100, 8'h06, 3);
        vecs[7]  = mk(0, 32'h000, 1, 0, 32'h240, 0, 0, 32'h100, 8'h0C, 4);
        vecs[8]  = mk(0, 32'h000, 1, 0, 32'h240, 0, 0, 32'h100, 8'h18, 5);
        vecs[9]  = mk(0, 32'h000, 1, 0, 32'h240, 0, 0, 32'h100, 8'h30, 6);
        vecs[10] = mk(0, 32'h000, 1, 0, 32'h240, 0, 0, 32'h100, 8'h60, 7);
        vecs[11] = mk(0, 32'h000, 1, 0, 32'h240, 0, 0, 32'h100, 8'hC0, 8);
        vecs[12] = mk(0, 32'h000, 1, 0, 32'h240, 0, 0, 32'h100, 8'h80, 9);
        vecs[13] = mk(0, 32'h000, 1, 0, 32'h240, 0, 0, 32'h100, 8'h00, 10);
        // Lookup together with an update to the same index: pre-shift ghr is used.
        vecs[14] = mk(1, 32'h100, 1, 1, 32'h100, 1, 1, 32'h100, 8'h01, 11);
        // Eight unrelated updates shift in 0,0,1,0,0,1,0,0 -> ghr 0x24.
        vecs[15] = mk(0, 32'h000, 1, 0, 32'h200, 0, 0, 32'h100, 8'h02, 12);
        vecs[16] = mk(0, 32'h000, 1, 0, 32'h200, 0, 0, 32'h100, 8'h04, 13);
        vecs[17] = mk(0, 32'h000, 1, 1, 32'h200, 0, 0, 32'h100, 8'h09, 14);
        vecs[18] = mk(0, 32'h000, 1, 0, 32'h200, 0, 0, 32'h100, 8'h12, 15);
        vecs[19] = mk(0, 32'h000, 1, 0, 32'h200, 0, 0, 32'h100, 8'h24, 16);
        vecs[20] = mk(0, 32'h000, 1, 1, 32'h200, 0, 0, 32'h100, 8'h49, 17);
        vecs[21] = mk(0, 32'h000, 1, 0, 32'h200, 0, 0, 32'h100, 8'h92, 18);
        vecs[22] = mk(0, 32'h000, 1, 0, 32'h200, 0, 0, 32'h100, 8'h24, 19);
        // Back-to-back taken updates all landing on idx 0x64: 01->10->11->11.
        vecs[23] = mk(0, 32'h000, 1, 1, 32'h100, 0, 0, 32'h100, 8'h49, 20);
        vecs[24] = mk(0, 32'h000, 1, 1, 32'h0B4, 0, 0, 32'h100, 8'h93, 21);
        vecs[25] = mk(0, 32'h000, 1, 1, 32'h3DC, 0, 0, 32'h100, 8'h27, 22);
        // Not-taken run on idx 0x64; each lookup sees the previous result: 11,10,01,00.
        vecs[26] = mk(1, 32'h10C, 1, 0, 32'h10C, 1, 1, 32'h10C, 8'h4E, 23);
        vecs[27] = mk(1, 32'h0A8, 1, 0, 32'h0A8, 1, 1, 32'h0A8, 8'h9C, 24);
        vecs[28] = mk(1, 32'h3E0, 1, 0, 32'h3E0, 1, 0, 32'h3E0, 8'h38, 25);
        vecs[29] = mk(1, 32'h170, 1, 0, 32'h170, 1, 0, 32'h170, 8'h70, 26);
        // Climb back from the floor: 00 (saturated) -> 01 -> 10.
        vecs[30] = mk(1, 32'h050, 1, 1, 32'h050, 1, 0, 32'h050, 8'hE1, 27);
        vecs[31] = mk(1, 32'h214, 1, 1, 32'h214, 1, 0, 32'h214, 8'hC3, 28);
        vecs[32] = mk(1, 32'h29C, 0, 0, 32'h000, 1, 1, 32'h29C, 8'hC3, 28);
        // Leaves a pending taken write to idx 0x40 in U2 right before reset.
        vecs[33] = mk(1, 32'h20C, 1, 1, 32'h20C, 1, 1, 32'h20C, 8'h87, 29);
        // After the async reset: table back to 01, pending write gone.
        vecs[34] = mk(1, 32'h100, 0, 0, 32'h000, 1, 0, 32'h100, 8'h00, 0);
        vecs[35] = mk(1, 32'h190, 0, 0, 32'h000, 1, 0, 32'h190, 8'h00, 0);
        vecs[36] = mk(0, 32'h000, 1, 1, 32'h100, 0, 0, 32'h190, 8'h01, 1);
        vecs[37] = mk(1, 32'h104, 0, 0, 32'h000, 1, 1, 32'h104, 8'h01, 1);

        rst = 1'b0;
        bp_if.lookup_valid = 1'b0;
        bp_if.lookup_pc    = '0;
        cmp_in = '{we: 1'b0, taken: 1'b0, pc: 32'h0};
        repeat (2) @(posedge clk);
        #1;
        $display("reset state: pv=%0b pt=%0b ppc=%03h ghr=%02h cnt=%0d",
                 bp_if.pred_valid, bp_if.pred_taken, bp_if.pred_pc, ghr_out, upd_cnt);
        chk_all("reset", 1'b0, 1'b0, 32'h0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i <= 33; i++) apply(i);

        // Asynchronous reset between edges while U2 holds a write.
        #2;
        rst = 1'b0;
        bp_if.lookup_valid = 1'b0;
        cmp_in = '{we: 1'b0, taken: 1'b0, pc: 32'h0};
        #1;
        $display("async reset: pv=%0b pt=%0b ppc=%03h ghr=%02h cnt=%0d",
                 bp_if.pred_valid, bp_if.pred_taken, bp_if.pred_pc, ghr_out, upd_cnt);
        chk_all("async_rst", 1'b0, 1'b0, 32'h0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 34; i < NVEC; i++) apply(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
